dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: debug/loader master.
- Latches one winning request, drives the memory's address/data/control for exactly one cycle, then returns registered read data with a done pulse.
- Sits between the MEM-stage load/store logic and the byte-addressed data memory, which has combinational read, posedge write, and a funct3-selected 4- or 8-byte access size.
- Port 0 uses p0_gnt/p0_done to generate its pipeline stall.

Parameters:
- ADDR_W, 64, request/memory address width
- DATA_W, 64, data width
- MEM_BYTES, 64, memory size in bytes, used for range checking
- STARVE_MAX, 4, consecutive port-0 grants while port 1 is waiting before port 1 is forced to win

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held, with fields stable, until p0_gnt
- p0_we  in  1  1 = store, 0 = load
- p0_funct3  in  3  size: 3'b010 = 4 B, 3'b011 = 8 B
- p0_addr  in  ADDR_W  byte address
- p0_wdata  in  DATA_W  store data
- p0_gnt  out  1  request accepted this cycle (combinational)
- p0_done  out  1  one-cycle completion pulse
- p0_err  out  1  valid with p0_done; access rejected
- p0_rdata  out  DATA_W  valid with p0_done for loads
- p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_gnt, p1_done, p1_err, p1_rdata: same set as port 0, same widths and meanings, for port 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_funct3  out  3  memory access size
- mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, starve_cnt = 0, latched request cleared.
  - All outputs 0. mem_write drops at once, so an in-flight write does not commit.
  - No done pulse is issued for an aborted transaction.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Only one transaction is outstanding at a time.
- IDLE:
  - gnt may assert only in IDLE, at most one port per cycle.
  - Winner selection:
    - port 1 if p1_req and (!p0_req or starve_cnt == STARVE_MAX);
    - otherwise port 0 if p0_req.
  - On a grant: latch {we, funct3, addr, wdata, id} and the error check result, then go to ACCESS.
  - starve_cnt: +1 on a port-0 grant while p1_req = 1 (saturates at STARVE_MAX); reset to 0 on a port-1 grant.
- Error check, evaluated at grant:
  - err if funct3 is not 010/011, or addr + size > MEM_BYTES.
  - The comparison uses an (ADDR_W+1)-bit sum, so no wrap-around.
  - Misaligned addresses are legal if in range.
- ACCESS (exactly one cycle):
  - If not err: drive mem_addr, mem_funct3, and either mem_read = !we or mem_write = we with mem_wdata.
  - If err: all mem_* outputs stay 0, so memory is untouched.
  - At the end of the cycle, register rdata: mem_rdata for a good load, 0 otherwise.
- RESP:
  - pX_done = 1 for the latched id, with pX_err and pX_rdata; the other port's done/err/rdata are 0.
  - Next state is IDLE; a new grant is possible in the following cycle.
- Latency: gnt in cycle N -> memory access in N+1 -> done in N+2. Sustained throughput is one transaction per 3 cycles.
- Idle outputs: all mem_* are 0. rdata holds 0 except during done.
- A requester dropping req before gnt is legal; nothing is latched.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Starvation counter and STARVE_MAX are unused.
  - Round-robin arbitration: on simultaneous requests, the port not granted last wins. last_gnt resets to port 1, so port 0 wins the first tie.
- Undefined: fixed priority with the starvation counter, as described in Behaviour.

Test Plan:
1. Reset asserted for 2 cycles -> every output 0, state IDLE, starve_cnt 0.
2. p0 store funct3=011, addr 8, wdata 0x1122334455667788; then p0 load from the same address -> each p0_done arrives 2 cycles after gnt; load returns p0_rdata = 0x1122334455667788, err 0.
3. p0_req and p1_req held high continuously, STARVE_MAX=4 -> grant order p0,p0,p0,p0,p1,p0,p0,p0,p0,p1; the corresponding done pulses each follow their grant by 2 cycles.
4. p1 load funct3=011, addr 60 -> p1_done with p1_err = 1 and p1_rdata = 0; mem_read never asserts. Same access at addr 56 -> err 0.
5. p0 store funct3=010, addr 16, wdata 0xDEADBEEF; reset asserted mid-ACCESS -> mem_write falls immediately, memory bytes 16-19 unchanged, no p0_done.
6. DMEM_ARB_RR_EN defined, both ports requesting continuously -> grants alternate p0,p1,p0,p1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle for the arbiter's two requester ports and its data-memory port.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              p0_req, p0_we, p0_gnt, p0_done, p0_err;
    logic [2:0]        p0_funct3;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_done, p1_err;
    logic [2:0]        p1_funct3;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_write, mem_read;
    logic [2:0]        mem_funct3;

    modport slave (
        input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        output p0_gnt, p0_done, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
        output p1_gnt, p1_done, p1_err, p1_rdata,
        output mem_addr, mem_wdata, mem_write, mem_read, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        input  p0_gnt, p0_done, p0_err, p0_rdata,
        output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
        input  p1_gnt, p1_done, p1_err, p1_rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read, mem_funct3,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port sequencer for the single data-memory port: grant, one access cycle, done.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority + starvation counter.
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_BYTES  = 64,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

    state_t                 state_q, state_d;
    logic                   id_q, id_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [2:0]             mem_funct3_q, mem_funct3_d;
    logic                   mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    logic [1:0]             done_q, done_d, perr_q, perr_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic              idle, pick1, gnt0, gnt1, sel_we, sel_bad;
    logic [2:0]        sel_f3;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W:0]   sel_end;

    // Grants are suppressed while reset is held so every output reads 0.
    assign idle = (state_q == IDLE) && !reset;
`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;  // 1 = port 1 won the most recent grant
    assign pick1 = bus.p1_req && (!bus.p0_req || !last_q);
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] starve_q, starve_d;
    assign pick1 = bus.p1_req && (!bus.p0_req || starve_q == STARVE_LIM);
`endif
    assign gnt1 = idle && pick1;
    assign gnt0 = idle && bus.p0_req && !pick1;

    assign sel_we    = pick1 ? bus.p1_we     : bus.p0_we;
    assign sel_f3    = pick1 ? bus.p1_funct3 : bus.p0_funct3;
    assign sel_addr  = pick1 ? bus.p1_addr   : bus.p0_addr;
    assign sel_wdata = pick1 ? bus.p1_wdata  : bus.p0_wdata;
    // One extra bit on the end address so a huge addr cannot wrap back in range.
    assign sel_end = {1'b0, sel_addr} + ((sel_f3 == 3'b010) ? (ADDR_W+1)'(4) : (ADDR_W+1)'(8));
    assign sel_bad = !(sel_f3 == 3'b010 || sel_f3 == 3'b011) || (sel_end > MEM_LIM);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        we_d         = we_q;
        err_d        = err_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_funct3_d = '0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        done_d       = '0;
        perr_d       = '0;
        rdata_d      = '0;
`ifdef DMEM_ARB_RR_EN
        last_d       = last_q;
`else
        starve_d     = starve_q;
`endif
        case (state_q)
            IDLE: if (gnt0 || gnt1) begin
                id_d    = gnt1;
                we_d    = sel_we;
                err_d   = sel_bad;
                state_d = ACCESS;
                // Memory signals are staged here so they come straight from flops in ACCESS.
                if (!sel_bad) begin
                    mem_addr_d   = sel_addr;
                    mem_funct3_d = sel_f3;
                    mem_read_d   = !sel_we;
                    mem_write_d  = sel_we;
                    mem_wdata_d  = sel_we ? sel_wdata : '0;
                end
`ifdef DMEM_ARB_RR_EN
                last_d = gnt1;
`else
                if (gnt1)                                  starve_d = '0;
                else if (bus.p1_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
`endif
            end
            ACCESS: begin
                state_d       = RESP;
                done_d[id_q]  = 1'b1;
                perr_d[id_q]  = err_q;
                rdata_d[id_q] = (!err_q && !we_q) ? bus.mem_rdata : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            done_q       <= '0;
            perr_q       <= '0;
            rdata_q      <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q       <= 1'b1;
`else
            starve_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            we_q         <= we_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_funct3_q <= mem_funct3_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            rdata_q      <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q       <= last_d;
`else
            starve_q     <= starve_d;
`endif
        end
    end

    assign bus.p0_gnt     = gnt0;
    assign bus.p1_gnt     = gnt1;
    assign bus.p0_done    = done_q[0];
    assign bus.p1_done    = done_q[1];
    assign bus.p0_err     = perr_q[0];
    assign bus.p1_err     = perr_q[1];
    assign bus.p0_rdata   = rdata_q[0];
    assign bus.p1_rdata   = rdata_q[1];
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_funct3 = mem_funct3_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_read   = mem_read_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0, mismatched = 0, cyc = 0;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(64), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Memory: combinational little-endian read, posedge write, initial bytes = address.
    byte unsigned tmem [64];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) tmem[i] <= 8'(i);
            mem_init <= 1'b1;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++)
                if (i < ((bus.mem_funct3 == 3'b010) ? 4 : 8) && int'(bus.mem_addr) + i < 64)
                    tmem[int'(bus.mem_addr) + i] <= bus.mem_wdata[i*8 +: 8];
        end
    end
    always @* begin
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (i < ((bus.mem_funct3 == 3'b010) ? 4 : 8) && bus.mem_addr + 64'(i) < 64)
                v[i*8 +: 8] = tmem[int'(bus.mem_addr) + i];
        bus.mem_rdata = v;
    end

    // Reference model: transaction phases and a shadow of memory contents.
    byte unsigned ref_mem [64];
    int ph, starve, last, m_id;
    bit m_we, m_err;
    logic [2:0]  m_f3;
    logic [63:0] m_addr, m_wd;

    function automatic int size_of(input logic [2:0] f3);
        return (f3 == 3'b010) ? 4 : 8;
    endfunction
    function automatic bit is_bad(input logic [2:0] f3, input logic [63:0] a);
        if (f3 != 3'b010 && f3 != 3'b011) return 1'b1;
        return ({1'b0, a} + 65'(size_of(f3))) > 65'd64;
    endfunction
    function automatic logic [63:0] ref_rd(input logic [63:0] a, input logic [2:0] f3);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < size_of(f3); i++) v[i*8 +: 8] = ref_mem[int'(a) + i];
        return v;
    endfunction

    initial begin : model
        bit s0, s1, sw0, sw1, w0, w1, tie1;
        logic [2:0] sf0, sf1, e_f3;
        logic [63:0] sa0, sa1, sd0, sd1, e_addr, e_wd;
        bit e_wr, e_rdn;
        bit [1:0] e_done, e_err;
        logic [63:0] e_rdata [2];
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);
        ph = 0; starve = 0; last = 1;
        forever begin
            @(negedge clk);
            s0 = bus.p0_req; sw0 = bus.p0_we; sf0 = bus.p0_funct3; sa0 = bus.p0_addr; sd0 = bus.p0_wdata;
            s1 = bus.p1_req; sw1 = bus.p1_we; sf1 = bus.p1_funct3; sa1 = bus.p1_addr; sd1 = bus.p1_wdata;
            w0 = 0; w1 = 0; e_f3 = '0; e_addr = '0; e_wd = '0; e_wr = 0; e_rdn = 0;
            e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
            if (reset) begin
                ph = 0; starve = 0; last = 1;
            end else begin
                case (ph)
                    0: begin
`ifdef DMEM_ARB_RR_EN
                        tie1 = (last == 0);
`else
                        tie1 = (starve == 4);
`endif
                        w1 = s1 && (!s0 || tie1);
                        w0 = s0 && !w1;
                    end
                    1: if (!m_err) begin
                        e_addr = m_addr; e_f3 = m_f3; e_rdn = !m_we; e_wr = m_we;
                        e_wd = m_we ? m_wd : '0;
                    end
                    default: begin
                        e_done[m_id] = 1'b1;
                        e_err[m_id]  = m_err;
                        e_rdata[m_id] = (!m_err && !m_we) ? ref_rd(m_addr, m_f3) : '0;
                    end
                endcase
            end
            chk("p0_gnt", bus.p0_gnt, w0);
            chk("p1_gnt", bus.p1_gnt, w1);
            chk("p0_done", bus.p0_done, e_done[0]);
            chk("p1_done", bus.p1_done, e_done[1]);
            chk("p0_err", bus.p0_err, e_err[0]);
            chk("p1_err", bus.p1_err, e_err[1]);
            chk("p0_rdata", bus.p0_rdata, e_rdata[0]);
            chk("p1_rdata", bus.p1_rdata, e_rdata[1]);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("mem_funct3", 64'(bus.mem_funct3), 64'(e_f3));
            chk("mem_write", bus.mem_write, e_wr);
            chk("mem_read", bus.mem_read, e_rdn);
            @(posedge clk);
            if (reset) begin
                ph = 0; starve = 0; last = 1;
            end else begin
                case (ph)
                    0: if (w0 || w1) begin
                        m_id = w1 ? 1 : 0;
                        m_we = w1 ? sw1 : sw0; m_f3 = w1 ? sf1 : sf0;
                        m_addr = w1 ? sa1 : sa0; m_wd = w1 ? sd1 : sd0;
                        m_err = is_bad(m_f3, m_addr);
                        if (w1) starve = 0;
                        else if (s1 && starve < 4) starve++;
                        last = w1 ? 1 : 0;
                        ph = 1;
                    end
                    1: begin
                        if (!m_err && m_we)
                            for (int i = 0; i < size_of(m_f3); i++) ref_mem[int'(m_addr) + i] = m_wd[i*8 +: 8];
                        ph = 2;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic drive(input int port, input bit req, input bit we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    task automatic xact(input int port, input bit we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output bit er,
                        output int lat, output bit any_rd);
        int g;
        bit got;
        rd = '0; er = 0; lat = -1; any_rd = 0; got = 0; g = 0;
        @(posedge clk); #1;
        drive(port, 1, we, f3, addr, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port == 1 ? bus.p1_gnt : bus.p0_gnt) begin got = 1; g = cyc; end
        end
        @(posedge clk); #1;
        drive(port, 0, 0, 3'b000, 64'd0, 64'd0);
        if (!got) begin chk("xact_gnt_seen", 0, 1); return; end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            any_rd |= bus.mem_read;
            if (port == 1 ? bus.p1_done : bus.p0_done) begin
                got = 1; lat = cyc - g;
                rd = (port == 1) ? bus.p1_rdata : bus.p0_rdata;
                er = (port == 1) ? bus.p1_err : bus.p0_err;
            end
        end
        if (!got) chk("xact_done_seen", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] rd;
        bit er, any_rd, got, seen;
        int lat, n;
        int order [10];
`ifdef DMEM_ARB_RR_EN
        int exp_order [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        drive(0, 0, 0, 3'b000, 64'd0, 64'd0);
        drive(1, 0, 0, 3'b000, 64'd0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_p0_done", bus.p0_done, 0);
        chk("rst_p1_rdata", bus.p1_rdata, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // Store then load the same doubleword.
        xact(0, 1, 3'b011, 64'd8, 64'h1122334455667788, rd, er, lat, any_rd);
        chk("t2_store_lat", 64'(lat), 2);
        chk("t2_store_err", er, 0);
        xact(0, 0, 3'b011, 64'd8, 64'd0, rd, er, lat, any_rd);
        chk("t2_load_lat", 64'(lat), 2);
        chk("t2_load_rdata", rd, 64'h1122334455667788);
        chk("t2_load_err", er, 0);

        // Both ports requesting continuously.
        pulse_reset();
        for (int i = 0; i < 10; i++) order[i] = -1;
        n = 0;
        drive(0, 1, 0, 3'b011, 64'd0, 64'd0);
        drive(1, 1, 0, 3'b010, 64'd4, 64'd0);
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clk);
            if (bus.p0_gnt) begin order[n] = 0; n++; end
            else if (bus.p1_gnt) begin order[n] = 1; n++; end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 3'b000, 64'd0, 64'd0);
        drive(1, 0, 0, 3'b000, 64'd0, 64'd0);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_grant_%0d", i), 64'(order[i]), 64'(exp_order[i]));
        repeat (3) @(posedge clk);

        // Out-of-range load is rejected without touching memory; the last legal doubleword works.
        xact(1, 0, 3'b011, 64'd60, 64'd0, rd, er, lat, any_rd);
        chk("t4_oor_err", er, 1);
        chk("t4_oor_rdata", rd, 0);
        chk("t4_oor_no_mem_read", any_rd, 0);
        chk("t4_oor_lat", 64'(lat), 2);
        xact(1, 0, 3'b011, 64'd56, 64'd0, rd, er, lat, any_rd);
        chk("t4_edge_err", er, 0);
        chk("t4_edge_rdata", rd, 64'h3F3E3D3C3B3A3938);
        chk("t4_edge_mem_read", any_rd, 1);
        xact(0, 0, 3'b001, 64'd0, 64'd0, rd, er, lat, any_rd);
        chk("t4_bad_funct3_err", er, 1);

        // Reset in the middle of a store's access cycle.
        @(posedge clk); #1;
        drive(0, 1, 1, 3'b010, 64'd16, 64'h00000000DEADBEEF);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.p0_gnt) got = 1;
        end
        chk("t5_gnt_seen", got, 1);
        @(posedge clk); #2;
        chk("t5_mem_write_in_access", bus.mem_write, 1);
        reset = 1'b1;
        drive(0, 0, 0, 3'b000, 64'd0, 64'd0);
        #1 chk("t5_mem_write_drops", bus.mem_write, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.p0_done;
        end
        chk("t5_no_done", seen, 0);
        chk("t5_mem_16_19", {32'd0, tmem[19], tmem[18], tmem[17], tmem[16]}, 64'h13121110);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
